// File: rtl/disp_wr_arbiter.sv
// disp_wr_arbiter: round-robin display RAM write-port arbiter with whole-screen fill engine.
// Fill engine and FILL state are compiled in only when DISP_ARB_FILL_EN is defined.
package disp_wr_arbiter_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    typedef logic [ADDR_W-1:0] disp_addr_t;
    typedef logic [DATA_W-1:0] disp_data_t;
endpackage

module disp_wr_arbiter
    import disp_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DISP_WORDS = 2400
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic       [NUM_REQ-1:0] req_valid_i,
    input  disp_addr_t [NUM_REQ-1:0] req_addr_i,
    input  disp_data_t [NUM_REQ-1:0] req_data_i,
    output logic       [NUM_REQ-1:0] req_ready_o,
    input  logic                     fill_start_i,
    input  disp_data_t               fill_data_i,
    output logic                     fill_busy_o,
    output logic                     wr_en_o,
    output disp_addr_t               wr_addr_o,
    output disp_data_t               wr_data_o,
    output logic       [1:0]         wr_src_o
);
    logic [1:0] ptr_q, ptr_d, gidx;
    logic       any, fill_blk;
    disp_addr_t sel_addr;
    disp_data_t sel_data;
    logic       wr_en_q;
    disp_addr_t wr_addr_q;
    disp_data_t wr_data_q;
    logic [1:0] wr_src_q;

    function automatic int wrap(input int s);
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    // Scan from the highest offset down so the last hit is the first valid at or after ptr_q.
    always_comb begin
        any = 1'b0;
        gidx = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[wrap(int'(ptr_q) + i)]) begin
                any = 1'b1;
                gidx = 2'(wrap(int'(ptr_q) + i));
                sel_addr = req_addr_i[wrap(int'(ptr_q) + i)];
                sel_data = req_data_i[wrap(int'(ptr_q) + i)];
            end
        end
    end

    assign ptr_d = (gidx == 2'(NUM_REQ - 1)) ? 2'd0 : gidx + 2'd1;
    assign req_ready_o = (reset_i || fill_blk || !any) ? '0 : {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx;

`ifdef DISP_ARB_FILL_EN
    typedef enum logic {ARB, FILL} state_t;
    localparam int CW = (DISP_WORDS > 1) ? $clog2(DISP_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DISP_WORDS - 1);
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    assign fill_blk = (state_q == FILL) || fill_start_i;
    assign fill_busy_o = (state_q == FILL);
`else
    logic unused_fill;
    assign unused_fill = ^{fill_start_i, fill_data_i};
    assign fill_blk = 1'b0;
    assign fill_busy_o = 1'b0;
`endif

    // Address 0 is written on the start edge, so cnt_q tracks the address currently on the bus.
    always_ff @(posedge clk) begin
        if (reset_i) begin
`ifdef DISP_ARB_FILL_EN
            state_q <= ARB;
            cnt_q <= '0;
`endif
            ptr_q <= '0;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q <= '0;
        end
`ifdef DISP_ARB_FILL_EN
        else if (state_q == FILL) begin
            wr_src_q <= '0;
            if (cnt_q == LAST) begin
                state_q <= ARB;
                wr_en_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                wr_en_q <= 1'b1;
                wr_addr_q <= ADDR_W'(cnt_q + 1'b1);
            end
        end else if (fill_start_i) begin
            state_q <= FILL;
            cnt_q <= '0;
            wr_en_q <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= fill_data_i;
            wr_src_q <= '0;
        end
`endif
        else begin
            wr_en_q <= any;
            if (any) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
                wr_src_q <= gidx;
                ptr_q <= ptr_d;
            end
        end
    end

    assign wr_en_o = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign wr_src_o = wr_src_q;
endmodule

// File: tb/tb_disp_wr_arbiter.sv
// tb_disp_wr_arbiter: directed checks of arbitration, fairness, pointer wrap and fill (NUM_REQ=3, DISP_WORDS=8).
module tb_disp_wr_arbiter;
    import disp_wr_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic       [2:0] req_valid = '0;
    disp_addr_t [2:0] req_addr = '0;
    disp_data_t [2:0] req_data = '0;
    logic       [2:0] req_ready;
    logic             fill_start = 1'b0;
    disp_data_t       fill_data = '0;
    logic             fill_busy, wr_en;
    disp_addr_t       wr_addr;
    disp_data_t       wr_data;
    logic       [1:0] wr_src;
    int total = 0;
    int bad = 0;

    disp_wr_arbiter #(.NUM_REQ(3), .DISP_WORDS(8)) dut (
        .clk(clk), .reset_i(reset), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_ready_o(req_ready), .fill_start_i(fill_start),
        .fill_data_i(fill_data), .fill_busy_o(fill_busy), .wr_en_o(wr_en),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_src_o(wr_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        req_valid = 3'b111;
        tick();
        tick();
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_addr", 32'(wr_addr), 0);
        chk("rst_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(fill_busy), 0);
        req_valid = '0;
        reset = 1'b0;
        tick();
        req_valid = 3'b001;
        req_addr[0] = 12'd5;
        req_data[0] = 16'h1F41;
        #1;
        chk("single_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        chk("single_en", 32'(wr_en), 1);
        chk("single_addr", 32'(wr_addr), 5);
        chk("single_data", 32'(wr_data), 32'h1F41);
        chk("single_src", 32'(wr_src), 0);
        tick();
        chk("idle_en", 32'(wr_en), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = disp_addr_t'(10 + i);
            req_data[i] = disp_data_t'(16'hA000 + i);
        end
        req_valid = 3'b111;
        for (int c = 0; c < 9; c++) begin
            #1;
            chk("fair_ready", 32'(req_ready), 32'(1) << (c % 3));
            tick();
            chk("fair_src", 32'(wr_src), 32'(c % 3));
            chk("fair_addr", 32'(wr_addr), 32'(10 + c % 3));
        end
        req_valid = 3'b010;
        #1;
        chk("resume_r1", 32'(req_ready), 32'b010);
        tick();
        req_valid = 3'b011;
        #1;
        chk("resume_wrap", 32'(req_ready), 32'b001);
        tick();
        chk("resume_src0", 32'(wr_src), 0);
        #1;
        chk("resume_next", 32'(req_ready), 32'b010);
        tick();
        chk("resume_src1", 32'(wr_src), 1);
        req_valid = '0;
        tick();
`ifdef DISP_ARB_FILL_EN
        req_valid = 3'b001;
        fill_start = 1'b1;
        fill_data = 16'h0020;
        #1;
        chk("fill_start_ready", 32'(req_ready), 0);
        tick();
        fill_start = 1'b0;
        for (int a = 0; a < 8; a++) begin
            chk("fill_ready", 32'(req_ready), 0);
            chk("fill_busy", 32'(fill_busy), 1);
            chk("fill_en", 32'(wr_en), 1);
            chk("fill_addr", 32'(wr_addr), 32'(a));
            chk("fill_data", 32'(wr_data), 32'h0020);
            fill_start = (a == 3);
            tick();
            fill_start = 1'b0;
        end
        chk("fill_end_busy", 32'(fill_busy), 0);
        chk("fill_end_en", 32'(wr_en), 0);
        chk("fill_end_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        chk("post_fill_en", 32'(wr_en), 1);
        chk("post_fill_src", 32'(wr_src), 0);
        chk("post_fill_addr", 32'(wr_addr), 10);
        fill_start = 1'b1;
        fill_data = 16'h5555;
        tick();
        fill_start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_addr3", 32'(wr_addr), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_en", 32'(wr_en), 0);
        chk("abort_busy", 32'(fill_busy), 0);
        req_valid = 3'b010;
        req_addr[1] = 12'd7;
        req_data[1] = 16'hABCD;
        #1;
        chk("abort_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        chk("abort_req_en", 32'(wr_en), 1);
        chk("abort_req_addr", 32'(wr_addr), 7);
        chk("abort_req_data", 32'(wr_data), 32'hABCD);
        chk("abort_req_src", 32'(wr_src), 1);
`else
        req_valid = 3'b010;
        req_addr[1] = 12'd9;
        fill_start = 1'b1;
        fill_data = 16'h0020;
        #1;
        chk("nofill_ready", 32'(req_ready), 32'b010);
        tick();
        fill_start = 1'b0;
        req_valid = '0;
        chk("nofill_busy", 32'(fill_busy), 0);
        chk("nofill_en", 32'(wr_en), 1);
        chk("nofill_addr", 32'(wr_addr), 9);
        chk("nofill_src", 32'(wr_src), 1);
        tick();
        chk("nofill_idle_en", 32'(wr_en), 0);
        chk("nofill_idle_busy", 32'(fill_busy), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/disp_wr_arbiter.md
# disp_wr_arbiter

Display-memory write-port arbiter. Shares the single display RAM write port (`wr_en_o`/`wr_addr_o`/`wr_data_o`) between `NUM_REQ` write sources, such as the text test generator and a console writer, using a fair round-robin valid/ready handshake. It also contains a fill engine that clears or fills the whole display with one word. It sits between the write sources and the display RAM in the video top level.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `DISP_WORDS`, default 2400: number of display words written by a fill (addresses 0..DISP_WORDS-1); must fit in `disp_addr_t`.

Ports:
- `clk`  in  1  sole clock.
- `reset_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  NUM_REQ  per-requester write request.
- `req_addr_i`  in  NUM_REQ x disp_addr_t  per-requester write address.
- `req_data_i`  in  NUM_REQ x disp_data_t  per-requester write data.
- `req_ready_o`  out  NUM_REQ  grant / accept; transfer occurs when valid & ready.
- `fill_start_i`  in  1  single-cycle pulse that starts a fill.
- `fill_data_i`  in  disp_data_t  fill word; sampled on `fill_start_i`.
- `fill_busy_o`  out  1  high while the fill engine owns the port.
- `wr_en_o`  out  1  display RAM write enable.
- `wr_addr_o`  out  disp_addr_t  display RAM write address.
- `wr_data_o`  out  disp_data_t  display RAM write data.
- `wr_src_o`  out  2  index of the requester that produced the current write; 0 during fill writes.

## Operation
- FSM states: ARB and FILL.
- Reset state: ARB, round-robin pointer = 0, fill counter = 0.
- ARB state:
  - Each cycle, grant the first valid requester, searching from the pointer upward with wrap.
  - `req_ready_o` is combinational. It is one-hot or all-zero, and asserts only for a requester whose `req_valid_i` is high.
  - Requesters must not make valid depend on ready.
  - On a grant to requester k, the pointer becomes (k+1) mod NUM_REQ.
  - With no valid requester, the pointer is unchanged.
- Round-robin fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…; there is no starvation.
- Requester data-path rules:
  - The accepted addr/data is registered onto `wr_addr_o`/`wr_data_o` with `wr_en_o`=1 and `wr_src_o`=k.
  - At most one write is issued per cycle.
  - Address and data pass through unmodified; there is no width conversion.
- Fill start (ARB state):
  - `fill_start_i` high in ARB overrides arbitration. All `req_ready_o` are low that cycle, and the pointer is unchanged.
  - `fill_data_i` is latched, the counter is cleared to 0, and the FSM moves to FILL.
- FILL state:
  - Each cycle, issue a write of the latched word to address = counter, then increment the counter.
  - After the write of DISP_WORDS-1, the FSM returns to ARB.
  - All `req_ready_o` are held 0 in FILL.
  - `fill_start_i` during FILL is ignored; the fill does not restart.
- Counter width: the counter is sized to hold DISP_WORDS-1. The terminal compare is against DISP_WORDS-1; the counter never wraps past it.
- Reset during FILL aborts the fill immediately. All outputs return to reset values on the next edge.
- Reset values of outputs:
  - `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `wr_src_o`=0, `fill_busy_o`=0.
  - `req_ready_o`=0 while `reset_i` is high.

## Timing
- Requester write latency: handshake at edge T gives `wr_en_o` high during cycle T+1.
- Throughput: one write per cycle.
- Fill, with the start pulse sampled at edge T:
  - `fill_busy_o` is high from T+1 through T+DISP_WORDS.
  - `wr_en_o` is high from T+1 through T+DISP_WORDS, with addresses 0..DISP_WORDS-1 in order and no gaps.
- After a fill: the first requester grant is possible in cycle T+DISP_WORDS+1.
- `fill_busy_o` is registered (state==FILL); `req_ready_o` is combinational from state, pointer and `req_valid_i`.
- `wr_en_o` is low in any cycle that follows a cycle with no grant and no fill write.

## Configuration
- Macro: `DISP_ARB_FILL_EN`.
- Defined: the fill engine and FILL state are compiled in, as described above.
- Undefined:
  - The fill engine is removed.
  - `fill_start_i` and `fill_data_i` are ignored.
  - `fill_busy_o` is tied 0.
  - The FSM stays permanently in ARB.
  - The ports remain present so that top-level wiring is unchanged.

## Test plan
- Single requester: after reset, req 0 valid with addr 5, data 16'h1F41 → ready_0 high the same cycle; next cycle `wr_en_o`=1, `wr_addr_o`=5, `wr_data_o`=16'h1F41, `wr_src_o`=0.
- Fairness: NUM_REQ=3, all valid for 9 cycles → `wr_src_o` sequence 0,1,2,0,1,2,0,1,2; exactly one ready per cycle.
- Pointer resume: grant to req 1, then only req 0 and req 1 valid → next grant goes to req 0 (search starts at 2, wraps to 0), then req 1.
- Fill: DISP_WORDS=8, fill_start with data 16'h0020 while req 0 is valid → ready_0 low for 9 cycles (start cycle plus 8 fill cycles); `wr_en_o` writes addresses 0..7 with 16'h0020; ready_0 is reasserted in the cycle after `fill_busy_o` falls.
- Fill edge cases: a second fill_start pulse mid-fill does not extend the fill. Reset asserted at fill address 3 → `wr_en_o`=0 and `fill_busy_o`=0 after the edge; the next request is accepted normally.
- Macro undefined: fill_start pulse with req 1 valid → req 1 is granted normally, `fill_busy_o` stays 0, and no writes to address 0 occur from fill.
